controle_display_rpn: RTL
=========================

CONTROLE_DISPLAY_RPN -- requirements
Module: controle_display_rpn

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of Clock.
REQ-002 Clock  input  1  system clock.
REQ-003 Reset  input  1  asynchronous active-high reset.
REQ-004 Iniciar  input  1  conversion request; level is sampled only in IDLE.
REQ-005 Resultado  input  8  unsigned ALU result to convert.
REQ-006 TrocaBase  input  1  already-synchronised button level; each rising edge advances the display base.
REQ-007 Base  output  2  display base select: 00 = Dec, 01 = Hex, 10 = Oct.
REQ-008 Ocupado  output  1  high while a conversion is in progress.
REQ-009 Pronto  output  1  one-cycle pulse when new BCD digits become valid.
REQ-010 BcdCentena, BcdDezena, BcdUnidade  output  4 each  registered BCD digits of the last completed conversion.

Function
REQ-011 The FSM SHALL have three states, IDLE, CONV and DONE, and no other reachable state.
REQ-012 IDLE with Iniciar=1 at an edge SHALL, at that edge:
- load Resultado into an 8-bit shift register;
- clear the 12-bit scratch BCD register;
- clear the iteration counter;
- go to CONV.
REQ-013 In CONV, each edge SHALL perform one double-dabble iteration:
- add 3 to every scratch digit that is ≥5;
- shift {scratch, shift register} left by 1;
- increment the counter.
REQ-014 On the 8th CONV iteration (counter 7→8) the FSM SHALL go to DONE.
REQ-015 The edge leaving DONE SHALL:
- copy the scratch digits into BcdCentena, BcdDezena and BcdUnidade;
- assert Pronto for exactly one cycle;
- return to IDLE.
REQ-016 Latency: if Iniciar is sampled at edge 0, the digits and Pronto SHALL become visible after edge 9, and a new Iniciar SHALL be accepted at edge 10 at the earliest.
REQ-017 Ocupado SHALL be high exactly when the state is not IDLE (after edge 0 through edge 9).
REQ-018 Iniciar SHALL be ignored in CONV and DONE, and Resultado changes after edge 0 SHALL NOT affect the conversion in progress.
REQ-019 BCD outputs SHALL hold their previous value throughout a conversion and change only at the DONE exit edge.
REQ-020 BcdCentena SHALL never exceed 2, and every digit SHALL stay in the range 0–9.
REQ-021 A rising edge on TrocaBase SHALL be detected against a registered copy of TrocaBase.
REQ-022 Each detected TrocaBase rising edge SHALL step Base 00→01→10→00; 11 SHALL never be produced.
REQ-023 Base stepping SHALL be independent of the conversion FSM and allowed in any state.
REQ-024 A TrocaBase level held high SHALL produce only one Base step.

Reset
REQ-025 Reset SHALL force, asynchronously:
- state = IDLE;
- counter = 0;
- shift and scratch registers = 0;
- Base = 00;
- Ocupado = 0 and Pronto = 0;
- all BCD outputs = 0;
- TrocaBase history register = 0.
REQ-026 Reset asserted during CONV or DONE SHALL abort the conversion without producing a Pronto pulse.
REQ-027 After reset deasserts, the first Iniciar SHALL start a fresh conversion with the normal latency.

Structure
REQ-028 A shared package SHALL hold:
- the FSM state encoding;
- the base constants BASE_DEC = 00, BASE_HEX = 01 and BASE_OCT = 10;
- the iteration count N_ITER = 8.
REQ-029 A combinational sub-module ajuste_bcd (4-bit in, 4-bit out, add 3 if ≥5) SHALL be instantiated once per scratch digit.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 Resultado=255, Iniciar pulse at edge 0 → after edge 9: digits 2/5/5, Pronto=1 for one cycle, Ocupado high across edges 1–9.
REQ-032 Resultado=0, then 99, then 100 → digits 0/0/0, then 0/9/9, then 1/0/0.
REQ-033 Iniciar held high continuously with Resultado changed mid-conversion → the first result reflects the value sampled at edge 0, and the next conversion starts at edge 10.
REQ-034 Reset asserted at edge 5 of a conversion of 200 → no Pronto pulse, digits 0/0/0, Base=00; a subsequent conversion of 200 gives 2/0/0.
REQ-035 Four TrocaBase pulses, one held high for 5 cycles → Base sequence 01, 10, 00, 01, with the held pulse counted once.
REQ-036 TrocaBase edge during CONV → Base steps, and the conversion result and timing are unchanged.

Source files
------------

// File: rtl/controle_display_rpn_pkg.sv
// Shared types and constants for the RPN display controller: FSM encoding,
// display base codes and binary-to-BCD conversion sizing.
package controle_display_rpn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] BASE_DEC = 2'b00;
    localparam logic [1:0] BASE_HEX = 2'b01;
    localparam logic [1:0] BASE_OCT = 2'b10;

    localparam int unsigned N_ITER = 8;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned N_DIG  = 3;
    localparam int unsigned BCD_W  = DIG_W * N_DIG;
    localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/controle_display_rpn_ajuste_bcd.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module ajuste_bcd
    import controle_display_rpn_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DIG_W'(5)) begin
            dout = din + DIG_W'(3);
        end
    end

endmodule

// File: rtl/controle_display_rpn.sv
// Converts an 8-bit ALU result to three BCD digits with a sequential
// double-dabble, and cycles the display base on each button press.
module controle_display_rpn
    import controle_display_rpn_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Iniciar,
    input  logic [RES_W-1:0] Resultado,
    input  logic             TrocaBase,
    output logic [1:0]       Base,
    output logic             Ocupado,
    output logic             Pronto,
    output logic [DIG_W-1:0] BcdCentena,
    output logic [DIG_W-1:0] BcdDezena,
    output logic [DIG_W-1:0] BcdUnidade
);

    state_t             state;
    state_t             state_next;
    logic [RES_W-1:0]   shift_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               troca_q;
    logic               troca_rise;

    for (genvar i = 0; i < N_DIG; i++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .din  (scratch_q[DIG_W*i +: DIG_W]),
            .dout (scratch_adj[DIG_W*i +: DIG_W])
        );
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (Iniciar) state_next = ST_CONV;
            ST_CONV: if (cnt_q == CNT_W'(N_ITER - 1)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Conversion datapath and status outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            Ocupado    <= 1'b0;
            Pronto     <= 1'b0;
            BcdCentena <= '0;
            BcdDezena  <= '0;
            BcdUnidade <= '0;
        end else begin
            Ocupado <= (state_next != ST_IDLE);
            Pronto  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (Iniciar) begin
                        shift_q   <= Resultado;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                ST_CONV: begin
                    {scratch_q, shift_q} <= {scratch_adj[BCD_W-2:0], shift_q, 1'b0};
                    cnt_q                <= cnt_q + CNT_W'(1);
                end
                ST_DONE: begin
                    BcdCentena <= scratch_q[3*DIG_W-1:2*DIG_W];
                    BcdDezena  <= scratch_q[2*DIG_W-1:DIG_W];
                    BcdUnidade <= scratch_q[DIG_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign troca_rise = TrocaBase & ~troca_q;

    // Base selector steps Dec -> Hex -> Oct -> Dec on each button press
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            troca_q <= 1'b0;
            Base    <= BASE_DEC;
        end else begin
            troca_q <= TrocaBase;
            if (troca_rise) begin
                case (Base)
                    BASE_DEC: Base <= BASE_HEX;
                    BASE_HEX: Base <= BASE_OCT;
                    default:  Base <= BASE_DEC;
                endcase
            end
        end
    end

endmodule
